// File: rtl/tpu_host_sequencer.sv
// Purpose : host-side sequencer that streams one 2x2 TPU request as 8 load bytes and reassembles the 8-byte done stream into four signed 16-bit results.
// Latency : first load byte 1 cycle after request acceptance; rsp_valid 1 cycle after the last done byte is captured.
// Backpr. : req_ready only in IDLE; response is held on rsp_valid/rsp_ready until accepted, and no new request is taken in the handshake cycle.
// Optional: define TPU_HOST_TIMEOUT_EN to enable the WAIT/CAPTURE timeout (rsp_error); otherwise rsp_error is constant 0.
module tpu_host_sequencer #(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int TO_W           = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_weights,
    input  logic [31:0] req_inputs,
    input  logic        req_transpose,
    output logic        tpu_load_en,
    output logic [7:0]  tpu_in_data,
    output logic        tpu_transpose,
    input  logic        tpu_done,
    input  logic [7:0]  tpu_out_data,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_c00,
    output logic [15:0] rsp_c01,
    output logic [15:0] rsp_c10,
    output logic [15:0] rsp_c11,
    output logic        rsp_error
);

    // Elaboration guard: the timeout counter must be able to hold TIMEOUT_CYCLES.
    if (TIMEOUT_CYCLES >= (1 << TO_W)) begin : g_bad_cfg
        $error("tpu_host_sequencer: TO_W too narrow for TIMEOUT_CYCLES");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_WAIT,
        S_CAPTURE,
        S_RESP
    } state_t;

    // Result word in TPU output byte order: b0 is the MSB of c00.
    typedef struct packed {
        logic [15:0] c00;
        logic [15:0] c01;
        logic [15:0] c10;
        logic [15:0] c11;
    } rsp_t;

    state_t      state;
    state_t      state_nxt;
    logic [63:0] load_buf;
    logic [2:0]  load_cnt;
    logic [63:0] cap_buf;
    logic [2:0]  cap_idx;
    logic [63:0] cap_word;
    rsp_t        rsp_word;
    logic        accept;
    logic        load_last;
    logic        cap_fire;
    logic        cap_last;
    logic        rsp_fire;
    logic        timeout;

    // Capture buffer with the current done byte merged in at the active index.
    always_comb begin
        cap_word = cap_buf;
        for (int i = 0; i < 8; i++) begin
            if (tpu_done && (cap_idx == 3'(i))) begin
                cap_word[63-8*i -: 8] = tpu_out_data;
            end
        end
    end

    assign rsp_word = rsp_t'(cap_word);

`ifdef TPU_HOST_TIMEOUT_EN
    logic [TO_W-1:0] to_cnt;

    // A silent cycle at the limit while waiting on the TPU ends the transaction.
    always_comb begin
        timeout = 1'b0;
        if ((state == S_WAIT || state == S_CAPTURE) && !tpu_done &&
            (to_cnt == TO_W'(TIMEOUT_CYCLES - 1))) begin
            timeout = 1'b1;
        end
    end

    // Timeout counter: cleared while loading and on every captured byte.
    always_ff @(posedge clk) begin
        if (rst) begin
            to_cnt <= '0;
        end else if (state == S_WAIT || state == S_CAPTURE) begin
            if (tpu_done) begin
                to_cnt <= '0;
            end else begin
                to_cnt <= to_cnt + 1'b1;
            end
        end else begin
            to_cnt <= '0;
        end
    end

    // Error flag travels with the response and clears on its handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_error <= 1'b0;
        end else if (rsp_fire) begin
            rsp_error <= 1'b0;
        end else if (timeout) begin
            rsp_error <= 1'b1;
        end
    end
`else
    assign timeout   = 1'b0;
    assign rsp_error = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode and per-state control strobes.
    always_comb begin
        state_nxt = state;
        req_ready = 1'b0;
        accept    = 1'b0;
        load_last = 1'b0;
        cap_fire  = 1'b0;
        cap_last  = 1'b0;
        rsp_fire  = 1'b0;
        case (state)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    accept    = 1'b1;
                    state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                if (load_cnt == 3'd7) begin
                    load_last = 1'b1;
                    state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (tpu_done) begin
                    cap_fire  = 1'b1;
                    state_nxt = S_CAPTURE;
                end else if (timeout) begin
                    state_nxt = S_RESP;
                end
            end
            S_CAPTURE: begin
                if (tpu_done) begin
                    cap_fire = 1'b1;
                    if (cap_idx == 3'd7) begin
                        cap_last  = 1'b1;
                        state_nxt = S_RESP;
                    end
                end else if (timeout) begin
                    state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    rsp_fire  = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Load serialiser: w0 goes out with acceptance, the rest shift out of the buffer.
    always_ff @(posedge clk) begin
        if (rst) begin
            load_buf      <= '0;
            load_cnt      <= '0;
            tpu_load_en   <= 1'b0;
            tpu_in_data   <= '0;
            tpu_transpose <= 1'b0;
        end else if (accept) begin
            load_buf      <= {8'h00, req_inputs, req_weights[31:8]};
            load_cnt      <= '0;
            tpu_load_en   <= 1'b1;
            tpu_in_data   <= req_weights[7:0];
            tpu_transpose <= req_transpose;
        end else if (state == S_LOAD) begin
            if (load_last) begin
                tpu_load_en <= 1'b0;
                tpu_in_data <= '0;
            end else begin
                tpu_in_data <= load_buf[7:0];
                load_buf    <= load_buf >> 8;
                load_cnt    <= load_cnt + 3'd1;
            end
        end
    end

    // Capture path and response registers; missing bytes stay 0 from acceptance.
    always_ff @(posedge clk) begin
        if (rst) begin
            cap_buf   <= '0;
            cap_idx   <= '0;
            rsp_valid <= 1'b0;
            rsp_c00   <= '0;
            rsp_c01   <= '0;
            rsp_c10   <= '0;
            rsp_c11   <= '0;
        end else begin
            if (accept) begin
                cap_buf <= '0;
                cap_idx <= '0;
            end else if (cap_fire) begin
                cap_buf <= cap_word;
                cap_idx <= cap_idx + 3'd1;
            end
            if (cap_last || timeout) begin
                rsp_valid <= 1'b1;
                rsp_c00   <= rsp_word.c00;
                rsp_c01   <= rsp_word.c01;
                rsp_c10   <= rsp_word.c10;
                rsp_c11   <= rsp_word.c11;
            end else if (rsp_fire) begin
                rsp_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_tpu_host_sequencer.sv
// Purpose : self-checking bench for tpu_host_sequencer using load-byte and response scoreboards.
// Latency : checks 1-cycle acceptance-to-load and 1-cycle done-to-response timing.
// Backpr. : exercises rsp_ready stalls, gapped tpu_done and reset mid-load.
module tb_tpu_host_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_weights;
    logic [31:0] req_inputs;
    logic        req_transpose;
    logic        tpu_load_en;
    logic [7:0]  tpu_in_data;
    logic        tpu_transpose;
    logic        tpu_done;
    logic [7:0]  tpu_out_data;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_c00;
    logic [15:0] rsp_c01;
    logic [15:0] rsp_c10;
    logic [15:0] rsp_c11;
    logic        rsp_error;

    int checks = 0;
    int errors = 0;

    logic [7:0]  load_q[$];
    logic [64:0] rsp_q[$];

    localparam logic [63:0] BYTES_BASIC = 64'h0013_0016_002B_0032;
    localparam logic [63:0] BYTES_NEG   = 64'hFFFF_8000_7FFF_0000;
    localparam logic [64:0] EXP_BASIC   = {1'b0, 16'd19, 16'd22, 16'd43, 16'd50};
    localparam logic [64:0] EXP_NEG     = {1'b0, 16'hFFFF, 16'h8000, 16'h7FFF, 16'h0000};

    tpu_host_sequencer #(.TIMEOUT_CYCLES(16), .TO_W(8)) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_weights   (req_weights),
        .req_inputs    (req_inputs),
        .req_transpose (req_transpose),
        .tpu_load_en   (tpu_load_en),
        .tpu_in_data   (tpu_in_data),
        .tpu_transpose (tpu_transpose),
        .tpu_done      (tpu_done),
        .tpu_out_data  (tpu_out_data),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_c00       (rsp_c00),
        .rsp_c01       (rsp_c01),
        .rsp_c10       (rsp_c10),
        .rsp_c11       (rsp_c11),
        .rsp_error     (rsp_error)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_load(input logic [31:0] w, input logic [31:0] x);
        for (int k = 0; k < 4; k++) load_q.push_back(w[8*k +: 8]);
        for (int k = 0; k < 4; k++) load_q.push_back(x[8*k +: 8]);
    endtask

    // Checks the 8-byte load burst starting at the current sample point.
    task automatic check_load(input logic t, input bit noise);
        logic [7:0] exp;
        if (noise) begin
            tpu_done     = 1'b1;
            tpu_out_data = 8'hA5;
        end
        for (int k = 0; k < 8; k++) begin
            exp = 8'h00;
            if (load_q.size() > 0) exp = load_q.pop_front();
            checks++;
            if (tpu_load_en !== 1'b1 || tpu_in_data !== exp) begin
                errors++;
                $display("FAIL load_byte%0d: load_en=%b data=%h, required load_en=1 data=%h",
                         k, tpu_load_en, tpu_in_data, exp);
            end
            if (k == 0) begin
                checks++;
                if (tpu_transpose !== t) begin
                    errors++;
                    $display("FAIL load_transpose: tpu_transpose=%b, required %b", tpu_transpose, t);
                end
            end
            tick();
        end
        tpu_done     = 1'b0;
        tpu_out_data = 8'h00;
        checks++;
        if (tpu_load_en !== 1'b0) begin
            errors++;
            $display("FAIL load_end: load_en=%b, required 0", tpu_load_en);
        end
    endtask

    task automatic drive_req(input logic [31:0] w, input logic [31:0] x, input logic t, input bit noise);
        int n;
        n = 0;
        while (req_ready !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL req_ready_wait: req_ready=%b, required 1", req_ready);
        end
        req_valid     = 1'b1;
        req_weights   = w;
        req_inputs    = x;
        req_transpose = t;
        push_load(w, x);
        tick();
        req_valid = 1'b0;
        check_load(t, noise);
    endtask

    // Plays the TPU done stream; an optional gap of gap_len idle cycles precedes byte gap_at.
    task automatic tpu_send(input logic [63:0] bytes, input int gap_at, input int gap_len);
        for (int k = 0; k < 8; k++) begin
            if (k == gap_at) begin
                tpu_done = 1'b0;
                for (int g = 0; g < gap_len; g++) begin
                    tick();
                    checks++;
                    if (rsp_valid !== 1'b0) begin
                        errors++;
                        $display("FAIL gap_rsp_valid: rsp_valid=%b, required 0", rsp_valid);
                    end
                end
            end
            tpu_done     = 1'b1;
            tpu_out_data = bytes[63-8*k -: 8];
            tick();
        end
        tpu_done     = 1'b0;
        tpu_out_data = 8'h00;
        checks++;
        if (rsp_valid !== 1'b1) begin
            errors++;
            $display("FAIL rsp_latency: rsp_valid=%b one cycle after last byte, required 1", rsp_valid);
        end
    endtask

    // Waits for a response, compares against the scoreboard, then handshakes it.
    task automatic check_rsp();
        logic [64:0] exp;
        int n;
        n = 0;
        while (rsp_valid !== 1'b1 && n < 60) begin
            tick();
            n++;
        end
        checks++;
        if (rsp_valid !== 1'b1) begin
            errors++;
            $display("FAIL rsp_wait: rsp_valid=%b, required 1", rsp_valid);
        end
        exp = 65'h0;
        if (rsp_q.size() > 0) exp = rsp_q.pop_front();
        checks++;
        if (rsp_c00 !== exp[63:48]) begin
            errors++;
            $display("FAIL rsp_c00: got %h, required %h", rsp_c00, exp[63:48]);
        end
        checks++;
        if (rsp_c01 !== exp[47:32]) begin
            errors++;
            $display("FAIL rsp_c01: got %h, required %h", rsp_c01, exp[47:32]);
        end
        checks++;
        if (rsp_c10 !== exp[31:16]) begin
            errors++;
            $display("FAIL rsp_c10: got %h, required %h", rsp_c10, exp[31:16]);
        end
        checks++;
        if (rsp_c11 !== exp[15:0]) begin
            errors++;
            $display("FAIL rsp_c11: got %h, required %h", rsp_c11, exp[15:0]);
        end
        checks++;
        if (rsp_error !== exp[64]) begin
            errors++;
            $display("FAIL rsp_error: got %b, required %b", rsp_error, exp[64]);
        end
        checks++;
        if (req_ready !== 1'b0) begin
            errors++;
            $display("FAIL rsp_req_ready: req_ready=%b during response, required 0", req_ready);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL rsp_done: rsp_valid=%b req_ready=%b, required 0 and 1", rsp_valid, req_ready);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        checks++;
        if (req_ready !== 1'b1 || tpu_load_en !== 1'b0 || tpu_in_data !== 8'h00 ||
            tpu_transpose !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl: req_ready=%b load_en=%b data=%h transpose=%b, required 1 0 00 0",
                     req_ready, tpu_load_en, tpu_in_data, tpu_transpose);
        end
        checks++;
        if (rsp_valid !== 1'b0 || rsp_error !== 1'b0 || rsp_c00 !== 16'h0 ||
            rsp_c01 !== 16'h0 || rsp_c10 !== 16'h0 || rsp_c11 !== 16'h0) begin
            errors++;
            $display("FAIL reset_rsp: valid=%b err=%b c=%h %h %h %h, required all 0",
                     rsp_valid, rsp_error, rsp_c00, rsp_c01, rsp_c10, rsp_c11);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        drive_req(32'h0403_0201, 32'h0807_0605, 1'b0, 1'b0);
        rsp_q.push_back(EXP_BASIC);
        tpu_send(BYTES_BASIC, 8, 0);
        check_rsp();
    endtask

    task automatic test_negative();
        drive_req(32'h1122_3344, 32'h5566_7788, 1'b0, 1'b1);
        rsp_q.push_back(EXP_NEG);
        tpu_send(BYTES_NEG, 8, 0);
        check_rsp();
    endtask

    task automatic test_gapped();
        drive_req(32'h0403_0201, 32'h0807_0605, 1'b0, 1'b0);
        rsp_q.push_back(EXP_BASIC);
        tpu_send(BYTES_BASIC, 4, 3);
        check_rsp();
    endtask

    task automatic test_backpressure();
        logic [64:0] exp;
        drive_req(32'hDEAD_BEEF, 32'h0102_0304, 1'b0, 1'b0);
        rsp_q.push_back(EXP_BASIC);
        tpu_send(BYTES_BASIC, 8, 0);
        exp = rsp_q.pop_front();
        req_valid     = 1'b1;
        req_weights   = 32'hA0B0_C0D0;
        req_inputs    = 32'h1020_3040;
        req_transpose = 1'b1;
        for (int c = 0; c < 5; c++) begin
            checks++;
            if (rsp_valid !== 1'b1 || req_ready !== 1'b0 || tpu_load_en !== 1'b0 ||
                {rsp_c00, rsp_c01, rsp_c10, rsp_c11} !== exp[63:0]) begin
                errors++;
                $display("FAIL bp_hold%0d: valid=%b req_ready=%b load_en=%b c=%h%h%h%h, required 1 0 0 %h",
                         c, rsp_valid, req_ready, tpu_load_en, rsp_c00, rsp_c01, rsp_c10, rsp_c11, exp[63:0]);
            end
            tick();
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || tpu_load_en !== 1'b0) begin
            errors++;
            $display("FAIL bp_handshake: valid=%b req_ready=%b load_en=%b, required 0 1 0",
                     rsp_valid, req_ready, tpu_load_en);
        end
        push_load(32'hA0B0_C0D0, 32'h1020_3040);
        tick();
        req_valid = 1'b0;
        check_load(1'b1, 1'b0);
        rsp_q.push_back(EXP_NEG);
        tpu_send(BYTES_NEG, 8, 0);
        check_rsp();
    endtask

    task automatic test_reset_in_load();
        logic [7:0] exp;
        req_valid     = 1'b1;
        req_weights   = 32'h4433_2211;
        req_inputs    = 32'h8877_6655;
        req_transpose = 1'b1;
        push_load(32'h4433_2211, 32'h8877_6655);
        tick();
        req_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            exp = load_q.pop_front();
            checks++;
            if (tpu_load_en !== 1'b1 || tpu_in_data !== exp) begin
                errors++;
                $display("FAIL rl_byte%0d: load_en=%b data=%h, required 1 %h", k, tpu_load_en, tpu_in_data, exp);
            end
            if (k < 2) tick();
        end
        rst = 1'b1;
        tick();
        checks++;
        if (tpu_load_en !== 1'b0 || rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL rl_reset: load_en=%b rsp_valid=%b req_ready=%b, required 0 0 1",
                     tpu_load_en, rsp_valid, req_ready);
        end
        rst = 1'b0;
        load_q.delete();
        drive_req(32'hCAFE_F00D, 32'h0BAD_BEEF, 1'b0, 1'b0);
        rsp_q.push_back(EXP_BASIC);
        tpu_send(BYTES_BASIC, 8, 0);
        check_rsp();
    endtask

`ifdef TPU_HOST_TIMEOUT_EN
    task automatic test_timeout();
        int n;
        drive_req(32'h0403_0201, 32'h0807_0605, 1'b0, 1'b0);
        rsp_q.push_back({1'b1, 64'h0});
        n = 1;
        while (rsp_valid !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        checks++;
        if (n < 16 || n > 17) begin
            errors++;
            $display("FAIL timeout_cycle: rsp_valid at wait cycle %0d, required 16..17", n);
        end
        check_rsp();
    endtask
`endif

    initial begin
        rst           = 1'b1;
        req_valid     = 1'b0;
        req_weights   = '0;
        req_inputs    = '0;
        req_transpose = 1'b0;
        tpu_done      = 1'b0;
        tpu_out_data  = '0;
        rsp_ready     = 1'b0;
        test_reset();
        test_basic();
        test_negative();
        test_gapped();
        test_backpressure();
        test_reset_in_load();
`ifdef TPU_HOST_TIMEOUT_EN
        test_timeout();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
